// File: rtl/mpu9250_pkg.sv
// MPU-9250 register map, init values and reader state encoding.
// ID states exist only when MPU_WHOAMI_CHECK_EN is defined.
package mpu9250_pkg;

    localparam logic [6:0] REG_PWR_MGMT_1   = 7'h6B;
    localparam logic [6:0] REG_USER_CTRL    = 7'h6A;
    localparam logic [6:0] REG_ACCEL_CONFIG = 7'h1C;
    localparam logic [6:0] REG_ACCEL_XOUT_H = 7'h3B;
    localparam logic [6:0] REG_WHO_AM_I     = 7'h75;

    localparam logic [7:0] PWR_MGMT_1_INIT   = 8'h00;
    localparam logic [7:0] USER_CTRL_INIT    = 8'h10;
    localparam logic [7:0] ACCEL_CONFIG_INIT = 8'h00;
    localparam logic [7:0] WHOAMI_EXPECT     = 8'h71;

    localparam logic [2:0] LAST_INIT  = 3'd2;
    localparam logic [2:0] LAST_BURST = 3'd5;

    typedef enum logic [3:0] {
        RESET_IDLE,
        INIT_ISSUE,
        INIT_WAIT,
`ifdef MPU_WHOAMI_CHECK_EN
        ID_ISSUE,
        ID_WAIT,
        ID_FAIL,
`endif
        IDLE_WAIT,
        RD_ISSUE,
        RD_WAIT,
        PUBLISH
    } state_t;

    // {address, write byte} for init step i
    function automatic logic [14:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    init_cmd = {REG_PWR_MGMT_1, PWR_MGMT_1_INIT};
            3'd1:    init_cmd = {REG_USER_CTRL, USER_CTRL_INIT};
            default: init_cmd = {REG_ACCEL_CONFIG, ACCEL_CONFIG_INIT};
        endcase
    endfunction

endpackage

// File: rtl/mpu_tick_gen.sv
// Free-running sample tick: one-cycle pulse every PERIOD clocks while run=1.
module mpu_tick_gen #(
    parameter int PERIOD = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mpu_accel_reader.sv
// MPU-9250 init + periodic 6-byte accel burst reader over a byte-wide SPI stage.
// Optional WHO_AM_I check enabled by defining MPU_WHOAMI_CHECK_EN.
module mpu_accel_reader
    import mpu9250_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [6:0]  spi_address,
    output logic [7:0]  spi_wr_data,
    output logic        spi_rd_wr_sel,
    output logic        spi_start,
    input  logic        spi_busy,
    input  logic [7:0]  spi_rd_data,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        data_valid,
    output logic        init_done,
    output logic        overrun,
    output logic        id_error
);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             seen_busy_q, seen_busy_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       wr_q, wr_d;
    logic             rd_sel_q, rd_sel_d;
    logic [5:0][7:0]  shadow_q, shadow_d;
    logic [15:0]      ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic             valid_q, valid_d;
    logic             init_done_q, init_done_d;
    logic             overrun_q, overrun_d;
    logic             id_error_q, id_error_d;
    logic             start_c, wait_done, tick;

    mpu_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (init_done_q),
        .tick (tick)
    );

    // Completion needs busy seen high first; the slave may still be low the cycle after start.
    assign wait_done = seen_busy_q && !spi_busy;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seen_busy_d = seen_busy_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        rd_sel_d    = rd_sel_q;
        shadow_d    = shadow_q;
        ax_d        = ax_q;
        ay_d        = ay_q;
        az_d        = az_q;
        valid_d     = 1'b0;
        init_done_d = init_done_q;
        id_error_d  = id_error_q;
        start_c     = 1'b0;
        overrun_d   = tick && enable && (state_q != IDLE_WAIT);

        case (state_q)
            RESET_IDLE: begin
                idx_d            = 3'd0;
                {addr_d, wr_d}   = init_cmd(3'd0);
                rd_sel_d         = 1'b0;
                state_d          = INIT_ISSUE;
            end
            INIT_ISSUE: if (!spi_busy) begin
                start_c     = 1'b1;
                seen_busy_d = 1'b0;
                state_d     = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (spi_busy) seen_busy_d = 1'b1;
                if (wait_done) begin
                    if (idx_q == LAST_INIT) begin
`ifdef MPU_WHOAMI_CHECK_EN
                        addr_d   = REG_WHO_AM_I;
                        wr_d     = 8'h00;
                        rd_sel_d = 1'b1;
                        state_d  = ID_ISSUE;
`else
                        init_done_d = 1'b1;
                        state_d     = IDLE_WAIT;
`endif
                    end else begin
                        idx_d          = idx_q + 3'd1;
                        {addr_d, wr_d} = init_cmd(idx_q + 3'd1);
                        state_d        = INIT_ISSUE;
                    end
                end
            end
`ifdef MPU_WHOAMI_CHECK_EN
            ID_ISSUE: if (!spi_busy) begin
                start_c     = 1'b1;
                seen_busy_d = 1'b0;
                state_d     = ID_WAIT;
            end
            ID_WAIT: begin
                if (spi_busy) seen_busy_d = 1'b1;
                if (wait_done) begin
                    if (spi_rd_data == WHOAMI_EXPECT) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE_WAIT;
                    end else begin
                        id_error_d = 1'b1;
                        state_d    = ID_FAIL;
                    end
                end
            end
            ID_FAIL: state_d = ID_FAIL;
`endif
            IDLE_WAIT: if (tick && enable) begin
                idx_d    = 3'd0;
                addr_d   = REG_ACCEL_XOUT_H;
                wr_d     = 8'h00;
                rd_sel_d = 1'b1;
                state_d  = RD_ISSUE;
            end
            RD_ISSUE: if (!spi_busy) begin
                start_c     = 1'b1;
                seen_busy_d = 1'b0;
                state_d     = RD_WAIT;
            end
            RD_WAIT: begin
                if (spi_busy) seen_busy_d = 1'b1;
                if (wait_done) begin
                    shadow_d[idx_q] = spi_rd_data;
                    if (idx_q == LAST_BURST) begin
                        state_d = PUBLISH;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        addr_d  = REG_ACCEL_XOUT_H + 7'(idx_q + 3'd1);
                        state_d = RD_ISSUE;
                    end
                end
            end
            PUBLISH: begin
                ax_d    = {shadow_q[0], shadow_q[1]};
                ay_d    = {shadow_q[2], shadow_q[3]};
                az_d    = {shadow_q[4], shadow_q[5]};
                valid_d = 1'b1;
                state_d = IDLE_WAIT;
            end
            default: state_d = RESET_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_IDLE;
            idx_q       <= 3'd0;
            seen_busy_q <= 1'b0;
            addr_q      <= 7'd0;
            wr_q        <= 8'd0;
            rd_sel_q    <= 1'b0;
            shadow_q    <= '0;
            ax_q        <= 16'd0;
            ay_q        <= 16'd0;
            az_q        <= 16'd0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            id_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seen_busy_q <= seen_busy_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            rd_sel_q    <= rd_sel_d;
            shadow_q    <= shadow_d;
            ax_q        <= ax_d;
            ay_q        <= ay_d;
            az_q        <= az_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
            overrun_q   <= overrun_d;
            id_error_q  <= id_error_d;
        end
    end

    // Gated by rst so a request in flight is withdrawn in the reset cycle itself.
    assign spi_start     = start_c && !rst;
    assign spi_address   = addr_q;
    assign spi_wr_data   = wr_q;
    assign spi_rd_wr_sel = rd_sel_q;
    assign accel_x       = ax_q;
    assign accel_y       = ay_q;
    assign accel_z       = az_q;
    assign data_valid    = valid_q;
    assign init_done     = init_done_q;
    assign overrun       = overrun_q;
`ifdef MPU_WHOAMI_CHECK_EN
    assign id_error      = id_error_q;
`else
    assign id_error      = 1'b0;
`endif

endmodule

// File: tb/tb_mpu_accel_reader.sv
// Directed bench for mpu_accel_reader: busy-model SPI slave, transaction and sample scoreboards.
module tb_mpu_accel_reader;

    localparam int PER = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [6:0]  spi_address;
    logic [7:0]  spi_wr_data;
    logic        spi_rd_wr_sel;
    logic        spi_start;
    logic        spi_busy;
    logic [7:0]  spi_rd_data;
    logic [15:0] accel_x, accel_y, accel_z;
    logic        data_valid, init_done, overrun, id_error;

    mpu_accel_reader #(.SAMPLE_PERIOD(PER)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .spi_address   (spi_address),
        .spi_wr_data   (spi_wr_data),
        .spi_rd_wr_sel (spi_rd_wr_sel),
        .spi_start     (spi_start),
        .spi_busy      (spi_busy),
        .spi_rd_data   (spi_rd_data),
        .accel_x       (accel_x),
        .accel_y       (accel_y),
        .accel_z       (accel_z),
        .data_valid    (data_valid),
        .init_done     (init_done),
        .overrun       (overrun),
        .id_error      (id_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
        logic       rw;
    } txn_t;

    txn_t        exp_t[$];
    logic [47:0] exp_s[$];
    logic [7:0]  mem[0:127];
    int          n_asserts = 0;
    int          n_fails = 0;
    int          start_cnt = 0;
    int          sample_cnt = 0;
    int          ovr_cnt = 0;
    int          busy_len = 1600;
    logic [6:0]  last_addr = 7'd0;
    logic        prev_start = 1'b0;
    logic        prev_valid = 1'b0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: busy stays low the cycle after start, then high for busy_len cycles.
    int ph = 0;
    int bcnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            ph = 0;
            spi_busy <= 1'b0;
        end else begin
            case (ph)
                0: if (spi_start) ph = 1;
                1: begin spi_busy <= 1'b1; bcnt = busy_len; ph = 2; end
                default: begin
                    bcnt--;
                    if (bcnt == 0) begin spi_busy <= 1'b0; ph = 0; end
                end
            endcase
        end
    end
    assign spi_rd_data = mem[spi_address];

    always @(negedge clk) begin
        if (!rst) begin
            if (spi_start) begin
                start_cnt++;
                last_addr = spi_address;
                check("start_width", {47'd0, prev_start}, 48'd0);
                check("start_bus_idle", {47'd0, spi_busy}, 48'd0);
                check("start_expected", {47'd0, exp_t.size() != 0}, 48'd1);
                if (exp_t.size() != 0) begin
                    txn_t t;
                    t = exp_t.pop_front();
                    check("txn_addr", {41'd0, spi_address}, {41'd0, t.a});
                    check("txn_wdata", {40'd0, spi_wr_data}, {40'd0, t.d});
                    check("txn_rw", {47'd0, spi_rd_wr_sel}, {47'd0, t.rw});
                end
            end
            if (spi_busy)
                check("addr_stable", {41'd0, spi_address}, {41'd0, last_addr});
            if (data_valid) begin
                sample_cnt++;
                check("valid_width", {47'd0, prev_valid}, 48'd0);
                check("sample_expected", {47'd0, exp_s.size() != 0}, 48'd1);
                if (exp_s.size() != 0)
                    check("sample", {accel_x, accel_y, accel_z}, exp_s.pop_front());
            end
            if (overrun) ovr_cnt++;
        end
        prev_start = spi_start && !rst;
        prev_valid = data_valid && !rst;
    end

    task automatic push_init();
        exp_t.push_back('{7'h6B, 8'h00, 1'b0});
        exp_t.push_back('{7'h6A, 8'h10, 1'b0});
        exp_t.push_back('{7'h1C, 8'h00, 1'b0});
`ifdef MPU_WHOAMI_CHECK_EN
        exp_t.push_back('{7'h75, 8'h00, 1'b1});
`endif
    endtask

    task automatic push_burst(input logic [47:0] bytes);
        for (int i = 0; i < 6; i++) begin
            mem[7'h3B + i] = bytes[47 - 8*i -: 8];
            exp_t.push_back('{7'(7'h3B + i), 8'h00, 1'b1});
        end
        exp_s.push_back(bytes);
    endtask

    task automatic wait_init(input int budget);
        int c = 0;
        while (!init_done && c < budget) begin @(negedge clk); c++; end
        check("init_done", {47'd0, init_done}, 48'd1);
        check("init_txns_consumed", 48'(exp_t.size()), 48'd0);
    endtask

    task automatic wait_samples(input int n, input int budget);
        int c = 0;
        while (sample_cnt < n && c < budget) begin @(negedge clk); c++; end
        check("sample_count", 48'(sample_cnt), 48'(n));
    endtask

    initial begin
        int base, ovr0, c;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h75] = 8'h71;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_start", {47'd0, spi_start}, 48'd0);
        check("rst_addr", {41'd0, spi_address}, 48'd0);
        check("rst_wdata", {40'd0, spi_wr_data}, 48'd0);
        check("rst_rw", {47'd0, spi_rd_wr_sel}, 48'd0);
        check("rst_accel", {accel_x, accel_y, accel_z}, 48'd0);
        check("rst_flags", {44'd0, data_valid, init_done, overrun, id_error}, 48'd0);

        // Init sequence with slow busy
        push_init();
        rst = 1'b0;
        wait_init(12000);
        check("id_error_ok", {47'd0, id_error}, 48'd0);

        // enable=0: no traffic for 5 periods
        base = start_cnt;
        repeat (5 * PER + 50) @(negedge clk);
        check("disabled_no_start", 48'(start_cnt), 48'(base));

        // Basic burst
        busy_len = 20;
        push_burst(48'h0102_FFFE_4000);
        enable = 1'b1;
        wait_samples(1, 3 * PER);
        enable = 1'b0;
        check("accel_x", {32'd0, accel_x}, 48'h0102);
        check("accel_y", {32'd0, accel_y}, 48'hFFFE);
        check("accel_z", {32'd0, accel_z}, 48'h4000);

        // Enable drops mid-burst; burst still completes, partial burst leaves outputs alone
        push_burst(48'h1234_5678_9ABC);
        base = start_cnt;
        enable = 1'b1;
        c = 0;
        while (start_cnt < base + 2 && c < 3 * PER) begin @(negedge clk); c++; end
        enable = 1'b0;
        check("partial_hold", {accel_x, accel_y, accel_z}, 48'h0102_FFFE_4000);
        wait_samples(2, 2 * PER);

        // Burst longer than two periods: two ticks dropped
        busy_len = 700;
        ovr0 = ovr_cnt;
        push_burst(48'hA5A5_0F0F_8001);
        enable = 1'b1;
        wait_samples(3, 4 * PER);
        enable = 1'b0;
        repeat (200) @(negedge clk);
        check("overrun_count", 48'(ovr_cnt - ovr0), 48'd2);
        check("overrun_sample_count", 48'(sample_cnt), 48'd3);

        // Reset during the read of 0x3D
        busy_len = 100;
        for (int i = 0; i < 3; i++) exp_t.push_back('{7'(7'h3B + i), 8'h00, 1'b1});
        last_addr = 7'd0;
        enable = 1'b1;
        c = 0;
        while (last_addr != 7'h3D && c < 3 * PER) begin @(negedge clk); c++; end
        check("reached_3d", {41'd0, last_addr}, 48'h3D);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        check("rst_drop_start", {47'd0, spi_start}, 48'd0);
        @(negedge clk);
        check("rst_mid_start", {47'd0, spi_start}, 48'd0);
        check("rst_mid_accel", {accel_x, accel_y, accel_z}, 48'd0);
        check("rst_mid_init", {47'd0, init_done}, 48'd0);
        enable = 1'b0;
        busy_len = 50;
        push_init();
        @(negedge clk);
        rst = 1'b0;
        wait_init(2000);

`ifdef MPU_WHOAMI_CHECK_EN
        // Wrong WHO_AM_I: sticky error, bus goes quiet
        rst = 1'b1;
        mem[7'h75] = 8'h68;
        @(negedge clk);
        push_init();
        base = start_cnt;
        rst = 1'b0;
        c = 0;
        while (!id_error && c < 2000) begin @(negedge clk); c++; end
        check("id_error_set", {47'd0, id_error}, 48'd1);
        check("id_fail_init", {47'd0, init_done}, 48'd0);
        enable = 1'b1;
        repeat (3 * PER) @(negedge clk);
        check("id_fail_quiet", 48'(start_cnt), 48'(base + 4));
        check("id_error_sticky", {47'd0, id_error}, 48'd1);
        enable = 1'b0;
`endif

        check("no_extra_samples", 48'(exp_s.size()), 48'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/mpu_accel_reader.md
MPU_ACCEL_READER -- requirements
Module: mpu_accel_reader

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 100000, clocks between burst-read starts (1 kHz @ 100 MHz); legal range >= 2000.
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-003 SHALL have port rst  input  1  reset; rst is synchronous, active-high, on clock clk.
REQ-004 SHALL have port enable  input  1  permits new burst reads once init is complete.
REQ-005 SHALL have port spi_address  output  7  register address to SPI stage.
REQ-006 SHALL have port spi_wr_data  output  8  write byte to SPI stage.
REQ-007 SHALL have port spi_rd_wr_sel  output  1  1 = read, 0 = write.
REQ-008 SHALL have port spi_start  output  1  one-cycle transaction request.
REQ-009 SHALL have port spi_busy  input  1  SPI stage busy.
REQ-010 SHALL have port spi_rd_data  input  8  read byte from SPI stage.
REQ-011 SHALL have port accel_x, accel_y, accel_z  output  16 each  signed samples, big-endian register pairs.
REQ-012 SHALL have port data_valid  output  1  one-cycle pulse when the accel outputs update.
REQ-013 SHALL have port init_done  output  1  high once the init sequence completes.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse when a sample tick is dropped.
REQ-015 SHALL have port id_error  output  1  WHO_AM_I mismatch, sticky.

Function
REQ-016 SHALL use states RESET_IDLE, INIT_ISSUE, INIT_WAIT, [ID_ISSUE, ID_WAIT, ID_FAIL], IDLE_WAIT, RD_ISSUE, RD_WAIT, PUBLISH.
REQ-017 SHALL run the init writes in order: 0x6B <- 0x00, 0x6A <- 0x10, 0x1C <- 0x00, then set init_done=1.
REQ-018 SHALL drive spi_address, spi_wr_data and spi_rd_wr_sel stable from the ISSUE cycle until the matching WAIT completes.
REQ-019 SHALL pulse spi_start for exactly one cycle in an ISSUE state, only when spi_busy=0.
REQ-020 SHALL complete a WAIT state only after spi_busy has been seen high and then low; busy low in the first cycle after start SHALL NOT count as completion.
REQ-021 SHALL sample spi_rd_data in the cycle where WAIT completes for a read.
REQ-022 SHALL generate a sample tick every SAMPLE_PERIOD cycles, starting after init_done rises.
REQ-023 SHALL move from IDLE_WAIT to RD_ISSUE on a tick while enable=1.
REQ-024 SHALL ignore a tick that arrives while enable=0.
REQ-025 SHALL, on a tick outside IDLE_WAIT with enable=1, drop the tick and pulse overrun.
REQ-026 SHALL, per burst, read the six addresses 0x3B..0x40 with a 3-bit index 0..5, holding bytes in a shadow buffer.
REQ-027 SHALL, in PUBLISH, update all three accel outputs together: accel_x={b0,b1}, accel_y={b2,b3}, accel_z={b4,b5}; data_valid=1 for that cycle only; then return to IDLE_WAIT.
REQ-028 SHALL leave the accel outputs unchanged by a partial burst.
REQ-029 SHALL let a burst already started finish even if enable falls mid-burst.

Reset
REQ-030 SHALL, while rst=1, reset spi_start=0, spi_address=0, spi_wr_data=0, spi_rd_wr_sel=0, accel_*=0, data_valid=0, init_done=0, overrun=0, id_error=0, tick counter=0, state=RESET_IDLE.
REQ-031 SHALL, on reset mid-transaction, drop spi_start the same cycle and restart the init sequence after reset is released.
REQ-032 SHALL leave RESET_IDLE on the first cycle after reset is released.

Configuration
REQ-033 SHALL, with MPU_WHOAMI_CHECK_EN defined, read 0x75 after init and before init_done; data 0x71 sets init_done, any other value enters ID_FAIL (id_error=1, no further transactions until rst).
REQ-034 SHALL, without MPU_WHOAMI_CHECK_EN, omit the ID states and tie id_error to 0.

Structure
REQ-035 SHALL take from package mpu9250_pkg: register addresses (0x6B, 0x6A, 0x1C, 0x3B, 0x75), init values, WHOAMI_EXPECT=0x71, and the state enumeration.
REQ-036 SHALL implement the tick generator as sub-module mpu_tick_gen (clk, rst, run, tick).

Verification
REQ-037 SHALL check: reset release with a busy model (busy low 1 cycle after start, then high 1600 cycles) -> three writes (0x6B/0x00, 0x6A/0x10, 0x1C/0x00), each spi_start exactly 1 cycle wide, then init_done=1.
REQ-038 SHALL check: slave returns 0x01,0x02,0xFF,0xFE,0x40,0x00 -> accel_x=0x0102, accel_y=0xFFFE, accel_z=0x4000, one data_valid pulse.
REQ-039 SHALL check: SAMPLE_PERIOD=2000 with a burst taking >2000 cycles -> one overrun pulse per dropped tick, no corrupt data.
REQ-040 SHALL check: enable=0 after init -> no spi_start for 5 periods; enable low mid-burst -> that burst completes and publishes.
REQ-041 SHALL check: rst asserted during a read of 0x3D -> spi_start=0 and accel outputs=0 next cycle; the init sequence reruns.
REQ-042 SHALL check, with MPU_WHOAMI_CHECK_EN: 0x71 -> init_done=1; 0x68 -> id_error=1, init_done=0, no further spi_start.
